// File: rtl/ndp_pkg.sv
// Shared constants for the NDP core datapath.
// Latency: n/a (package only).
// Backpressure: n/a (package only).
package ndp_pkg;

  // FP16 result element width and the AXI4-Stream data width it packs into.
  localparam int FP16_WIDTH  = 16;
  localparam int AXIS_DATA_W = 32;

  // Frame FSM for the egress path.
  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    FIN  = 2'd2
  } state_e;

endpackage

// File: rtl/ndp_sync_fifo.sv
// Synchronous first-word-fall-through FIFO; dout shows the head word whenever !empty.
// Latency: a pushed word is visible at dout the cycle after the push when the FIFO was empty.
// Backpressure: full blocks push unless a pop happens in the same cycle; pop on empty is ignored.
// Ports: axi_aclk/axi_aresetn (sync, active-low), push/din write side, pop/dout read side, full/empty status.
module ndp_sync_fifo #(
  parameter int WIDTH = 32,
  parameter int DEPTH = 16
) (
  input  logic             axi_aclk,
  input  logic             axi_aresetn,
  input  logic             push,
  input  logic             pop,
  input  logic [WIDTH-1:0] din,
  output logic [WIDTH-1:0] dout,
  output logic             full,
  output logic             empty
);

  localparam int AW = $clog2(DEPTH);

  logic [WIDTH-1:0] mem_q [DEPTH];
  // One extra wrap bit on each pointer distinguishes full from empty.
  logic [AW:0]      wr_ptr_q, wr_ptr_d;
  logic [AW:0]      rd_ptr_q, rd_ptr_d;
  logic             do_push, do_pop;

  assign empty   = (wr_ptr_q == rd_ptr_q);
  assign full    = (wr_ptr_q[AW] != rd_ptr_q[AW]) &&
                   (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);
  assign do_pop  = pop && !empty;
  // A pop frees the slot this cycle, so push-while-full is safe alongside it.
  assign do_push = push && (!full || do_pop);
  assign dout    = mem_q[rd_ptr_q[AW-1:0]];

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    if (do_push) wr_ptr_d = wr_ptr_q + (AW+1)'(1);
    if (do_pop)  rd_ptr_d = rd_ptr_q + (AW+1)'(1);
  end

  always_ff @(posedge axi_aclk) begin
    if (!axi_aresetn) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
    end
  end

  // Storage needs no reset: empty masks stale contents.
  always_ff @(posedge axi_aclk) begin
    if (do_push) mem_q[wr_ptr_q[AW-1:0]] <= din;
  end

endmodule

// File: rtl/ndp_axis_result_tx.sv
// Egress stage: packs FP16 result pairs into 32-bit words and streams a framed AXI4-Stream master.
// Latency: odd element accepted at t -> word valid on m_axis at t+1 when the word FIFO was empty.
// Backpressure: tready low fills the word FIFO; in_ready drops when full or 2*len elements taken.
// Ports: start/frame_len/busy/done frame control, in_valid/in_ready/in_data element intake,
//        m_axis_tdata/tvalid/tready/tlast stream out; axi_aclk with sync active-low axi_aresetn.
module ndp_axis_result_tx
  import ndp_pkg::*;
#(
  parameter int WIDTH      = FP16_WIDTH,
  parameter int DATA_W     = AXIS_DATA_W,
  parameter int FIFO_DEPTH = 16,
  parameter int LEN_W      = 16
) (
  input  logic              axi_aclk,
  input  logic              axi_aresetn,
  input  logic              start,
  input  logic [LEN_W-1:0]  frame_len,
  output logic              busy,
  output logic              done,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [WIDTH-1:0]  in_data,
  output logic [DATA_W-1:0] m_axis_tdata,
  output logic              m_axis_tvalid,
  input  logic              m_axis_tready,
  output logic              m_axis_tlast
);

  state_e            state_q, state_d;
  logic [LEN_W-1:0]  len_q, len_d;
  logic [LEN_W:0]    ecnt_q, ecnt_d;   // elements taken; reaches 2*len
  logic [LEN_W-1:0]  bcnt_q, bcnt_d;   // beats sent
  logic [WIDTH-1:0]  lo_q, lo_d;       // even element waiting for its partner

  logic              fifo_full, fifo_empty, fifo_push;
  logic [DATA_W-1:0] fifo_dout;
  logic              in_hs, beat_hs;

  // in_ready depends on registered state only, never on in_valid.
  assign in_ready      = (state_q == RUN) && (ecnt_q < {len_q, 1'b0}) && !fifo_full;
  assign in_hs         = in_valid && in_ready;
  assign fifo_push     = in_hs && ecnt_q[0];

  assign m_axis_tvalid = (state_q == RUN) && !fifo_empty;
  assign m_axis_tdata  = m_axis_tvalid ? fifo_dout : '0;
  assign m_axis_tlast  = m_axis_tvalid && (bcnt_q == len_q - LEN_W'(1));
  assign beat_hs       = m_axis_tvalid && m_axis_tready;

  assign busy = (state_q != IDLE);
  assign done = (state_q == FIN);

  ndp_sync_fifo #(
    .WIDTH (DATA_W),
    .DEPTH (FIFO_DEPTH)
  ) u_word_fifo (
    .axi_aclk    (axi_aclk),
    .axi_aresetn (axi_aresetn),
    .push        (fifo_push),
    .pop         (beat_hs),
    .din         ({in_data, lo_q}),
    .dout        (fifo_dout),
    .full        (fifo_full),
    .empty       (fifo_empty)
  );

  always_comb begin
    state_d = state_q;
    len_d   = len_q;
    ecnt_d  = ecnt_q;
    bcnt_d  = bcnt_q;
    lo_d    = lo_q;
    case (state_q)
      IDLE: begin
        if (start) begin
          len_d   = frame_len;
          ecnt_d  = '0;
          bcnt_d  = '0;
          state_d = (frame_len == '0) ? FIN : RUN;
        end
      end
      RUN: begin
        if (in_hs) begin
          ecnt_d = ecnt_q + (LEN_W+1)'(1);
          if (!ecnt_q[0]) lo_d = in_data;
        end
        if (beat_hs) begin
          bcnt_d = bcnt_q + LEN_W'(1);
          if (m_axis_tlast) state_d = FIN;
        end
      end
      FIN:     state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge axi_aclk) begin
    if (!axi_aresetn) begin
      state_q <= IDLE;
      len_q   <= '0;
      ecnt_q  <= '0;
      bcnt_q  <= '0;
      lo_q    <= '0;
    end else begin
      state_q <= state_d;
      len_q   <= len_d;
      ecnt_q  <= ecnt_d;
      bcnt_q  <= bcnt_d;
      lo_q    <= lo_d;
    end
  end

endmodule

// File: tb/tb_ndp_axis_result_tx.sv
// Bench for ndp_axis_result_tx: random valid/ready traffic against a frame-level reference model.
// Latency: n/a.
// Backpressure: tready and in_valid are driven with per-scenario random duty cycles.
module tb_ndp_axis_result_tx;

  localparam int LEN_W = 16;
  localparam int DEPTH = 16;

  logic             axi_aclk = 1'b0;
  logic             axi_aresetn;
  logic             start;
  logic [LEN_W-1:0] frame_len;
  logic             busy, done;
  logic             in_valid, in_ready;
  logic [15:0]      in_data;
  logic [31:0]      m_axis_tdata;
  logic             m_axis_tvalid, m_axis_tready, m_axis_tlast;

  always #5 axi_aclk = ~axi_aclk;

  ndp_axis_result_tx #(
    .WIDTH      (16),
    .DATA_W     (32),
    .FIFO_DEPTH (DEPTH),
    .LEN_W      (LEN_W)
  ) dut (
    .axi_aclk      (axi_aclk),
    .axi_aresetn   (axi_aresetn),
    .start         (start),
    .frame_len     (frame_len),
    .busy          (busy),
    .done          (done),
    .in_valid      (in_valid),
    .in_ready      (in_ready),
    .in_data       (in_data),
    .m_axis_tdata  (m_axis_tdata),
    .m_axis_tvalid (m_axis_tvalid),
    .m_axis_tready (m_axis_tready),
    .m_axis_tlast  (m_axis_tlast)
  );

  int n_cmp = 0;
  int n_bad = 0;

  task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h at %0t", tag, act, exp, $time);
    end
  endtask

  // Reference model: frame phase, counts of elements/beats, and a queue of packed words.
  int          ph;      // 0 closed, 1 open, 2 completing
  int          m_len, acc, bts;
  logic [15:0] lo;
  logic [31:0] wq[$];
  logic [15:0] src[$];  // elements waiting to be offered
  int          vld_pct, rdy_pct;

  // Observed DUT activity.
  int          obs_beats, obs_lasts, obs_done, obs_elems;
  logic [31:0] obs_q[$];

  function automatic bit exp_tvalid();
    return (ph == 1) && (wq.size() > 0);
  endfunction

  function automatic bit exp_inrdy();
    return (ph == 1) && (acc < 2 * m_len) && (wq.size() < DEPTH);
  endfunction

  function automatic bit exp_tlast();
    return exp_tvalid() && (bts == m_len - 1);
  endfunction

  function automatic logic [31:0] exp_tdata();
    return exp_tvalid() ? wq[0] : 32'h0;
  endfunction

  task automatic model_edge();
    bit ihs, ohs;
    ihs = in_valid && exp_inrdy();
    ohs = m_axis_tready && exp_tvalid();
    if (!axi_aresetn) begin
      ph = 0; m_len = 0; acc = 0; bts = 0;
      wq.delete();
      return;
    end
    case (ph)
      0: if (start) begin
        m_len = int'(frame_len);
        acc = 0; bts = 0;
        ph = (m_len == 0) ? 2 : 1;
      end
      1: begin
        if (ohs) begin
          void'(wq.pop_front());
          bts++;
          if (bts == m_len) ph = 2;
        end
        if (ihs) begin
          if (acc % 2 == 0) lo = in_data;
          else wq.push_back({in_data, lo});
          acc++;
          void'(src.pop_front());
        end
      end
      default: ph = 0;
    endcase
  endtask

  task automatic compare();
    chk("busy",     32'(busy),          32'(ph != 0));
    chk("done",     32'(done),          32'(ph == 2));
    chk("in_ready", 32'(in_ready),      32'(exp_inrdy()));
    chk("tvalid",   32'(m_axis_tvalid), 32'(exp_tvalid()));
    chk("tlast",    32'(m_axis_tlast),  32'(exp_tlast()));
    chk("tdata",    m_axis_tdata,       exp_tdata());
  endtask

  task automatic drive();
    in_valid      = (src.size() > 0) && ($urandom_range(0, 99) < vld_pct);
    in_data       = in_valid ? src[0] : 16'($urandom);
    m_axis_tready = ($urandom_range(0, 99) < rdy_pct);
  endtask

  task automatic step();
    drive();
    if (m_axis_tvalid && m_axis_tready) begin
      obs_beats++;
      obs_q.push_back(m_axis_tdata);
      if (m_axis_tlast) obs_lasts++;
    end
    if (done) obs_done++;
    if (in_valid && in_ready) obs_elems++;
    @(posedge axi_aclk);
    model_edge();
    #1;
    compare();
  endtask

  task automatic clr_obs();
    obs_beats = 0; obs_lasts = 0; obs_done = 0; obs_elems = 0;
    obs_q.delete();
  endtask

  task automatic start_frame(input int len);
    start = 1'b1;
    frame_len = LEN_W'(len);
    step();
    start = 1'b0;
    frame_len = LEN_W'($urandom);
  endtask

  task automatic run_until_done(input int target, input int budget);
    for (int i = 0; i < budget && obs_done < target; i++) step();
    step();
  endtask

  task automatic load(input int first, input int n);
    for (int i = 0; i < n; i++) src.push_back(16'(first + i));
  endtask

  initial begin
    axi_aresetn = 1'b0; start = 1'b0; frame_len = '0;
    in_valid = 1'b0; in_data = '0; m_axis_tready = 1'b0;
    ph = 0; m_len = 0; acc = 0; bts = 0; lo = '0;
    vld_pct = 100; rdy_pct = 100;
    clr_obs();
    repeat (3) step();
    chk("rst_busy",   32'(busy),          32'h0);
    chk("rst_tvalid", 32'(m_axis_tvalid), 32'h0);
    chk("rst_tdata",  m_axis_tdata,       32'h0);
    axi_aresetn = 1'b1;
    step();

    // Basic two-beat frame.
    clr_obs(); src.delete();
    src.push_back(16'h1111); src.push_back(16'h2222);
    src.push_back(16'h3333); src.push_back(16'h4444);
    vld_pct = 100; rdy_pct = 100;
    start_frame(2);
    run_until_done(1, 50);
    chk("s1_beats", 32'(obs_beats), 32'd2);
    chk("s1_lasts", 32'(obs_lasts), 32'd1);
    chk("s1_done",  32'(obs_done),  32'd1);
    if (obs_q.size() == 2) begin
      chk("s1_w0", obs_q[0], 32'h22221111);
      chk("s1_w1", obs_q[1], 32'h44443333);
    end else chk("s1_nwords", 32'(obs_q.size()), 32'd2);
    chk("s1_busy", 32'(busy), 32'h0);

    // Backpressure fills the word FIFO.
    clr_obs(); src.delete(); load(0, 40);
    rdy_pct = 0;
    start_frame(20);
    repeat (40) step();
    chk("s2_elems_full", 32'(obs_elems), 32'd32);
    chk("s2_inrdy_full", 32'(in_ready),  32'h0);
    rdy_pct = 100;
    run_until_done(1, 200);
    chk("s2_beats", 32'(obs_beats), 32'd20);
    chk("s2_lasts", 32'(obs_lasts), 32'd1);
    chk("s2_elems", 32'(obs_elems), 32'd40);
    if (obs_q.size() == 20) chk("s2_last_word", obs_q[19], 32'h00270026);

    // Zero-length frame.
    clr_obs(); src.delete(); load(16'h5000, 2);
    start_frame(0);
    repeat (5) step();
    chk("s3_beats", 32'(obs_beats), 32'd0);
    chk("s3_elems", 32'(obs_elems), 32'd0);
    chk("s3_done",  32'(obs_done),  32'd1);

    // Reset in the middle of a frame.
    clr_obs(); src.delete(); load(16'h0100, 8);
    start_frame(4);
    for (int i = 0; i < 100 && obs_beats < 3; i++) step();
    axi_aresetn = 1'b0;
    step();
    chk("s4_busy",   32'(busy),          32'h0);
    chk("s4_tvalid", 32'(m_axis_tvalid), 32'h0);
    chk("s4_inrdy",  32'(in_ready),      32'h0);
    chk("s4_lasts",  32'(obs_lasts),     32'd0);
    axi_aresetn = 1'b1;
    src.delete();
    step();
    clr_obs();
    src.push_back(16'hAAAA); src.push_back(16'hBBBB);
    start_frame(1);
    run_until_done(1, 50);
    chk("s4_beats", 32'(obs_beats), 32'd1);
    chk("s4_lasts2", 32'(obs_lasts), 32'd1);
    if (obs_q.size() == 1) chk("s4_word", obs_q[0], 32'hBBBBAAAA);

    // start during an open frame is ignored.
    clr_obs(); src.delete(); load(16'h0200, 14);
    vld_pct = 60; rdy_pct = 60;
    start_frame(5);
    step(); step();
    start_frame(7);
    run_until_done(1, 200);
    chk("s5_beats", 32'(obs_beats), 32'd5);
    chk("s5_lasts", 32'(obs_lasts), 32'd1);

    // Back-to-back frames, second start right after done.
    clr_obs(); src.delete(); load(16'h0300, 8);
    vld_pct = 50; rdy_pct = 50;
    start_frame(3);
    for (int i = 0; i < 200 && !done; i++) step();
    step();
    start_frame(1);
    run_until_done(2, 200);
    chk("s6_beats", 32'(obs_beats), 32'd4);
    chk("s6_lasts", 32'(obs_lasts), 32'd2);
    chk("s6_done",  32'(obs_done),  32'd2);

    // Random frames.
    for (int f = 0; f < 8; f++) begin
      int len;
      len = $urandom_range(1, 24);
      clr_obs(); src.delete();
      load($urandom_range(0, 16'hF000), 2 * len + $urandom_range(0, 3));
      vld_pct = $urandom_range(20, 100);
      rdy_pct = $urandom_range(10, 100);
      start_frame(len);
      run_until_done(1, 2000);
      chk("rnd_beats", 32'(obs_beats), 32'(len));
      chk("rnd_lasts", 32'(obs_lasts), 32'd1);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
